// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer.
// Holds pc/operands/immediate payload plus control bundle; flush kills all held entries.
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 14,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              accept, drain;
    logic              main_ld_in, main_ld_skid, skid_ld;

    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state;
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt  = ST_ONE;
                        main_ld_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_ld_in = 1'b1;
                    end else if (accept && SKID) begin
                        state_nxt = ST_TWO;
                        skid_ld   = 1'b1;
                    end else if (drain) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_nxt    = ST_ONE;
                        main_ld_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Ctrl is zeroed whenever an entry is vacated so a bubble always reads as a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (main_ld_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (main_ld_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end else if (state_nxt == ST_EMPTY) begin
                main_ctrl <= '0;
            end

            if (skid_ld) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end else if (flush || main_ld_skid) begin
                skid_ctrl <= '0;
            end
        end
    end

    generate
        if (SKID) begin : g_skid_ready
            // Registered ready breaks the out_ready -> in_ready timing path.
            logic in_ready_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_nxt != ST_TWO);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_pass_ready
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

endmodule
